// File: rtl/su_pkg.sv
// Shared definitions for the psum-adder scheduler: FSM encoding, bank depth
// default and address-width derivation.
package su_pkg;

  localparam int SU_DEPTH  = 32;
  localparam int SU_TILE_W = 8;
  localparam int SU_CFG_W  = 5;

  // Address width for a bank of 'depth' words (never narrower than 1 bit).
  function automatic int su_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int SU_ADDR_W = su_addr_w(SU_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_PE = 3'd1,
    S_ADD     = 3'd2,
    S_SWAP    = 3'd3,
    S_FLUSH   = 3'd4,
    S_DONE    = 3'd5
  } su_state_e;

endpackage

// File: rtl/psum_bank_tracker.sv
// Per-bank bookkeeping for one psum GBF bank: full flag, saturating write
// count and sticky overflow flag.
module psum_bank_tracker import su_pkg::*; #(
  parameter  int DEPTH = SU_DEPTH,
  localparam int CNT_W = su_addr_w(DEPTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_req_i,    // adder write aimed at this bank
  input  logic set_full_i,  // tile finished into this bank
  input  logic clr_i,       // bank drained
  output logic wr_ok_o,     // write accepted (bank not saturated)
  output logic full_o,
  output logic ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             room;

  assign room    = cnt_q < CNT_W'(DEPTH);
  assign wr_ok_o = wr_req_i & room;
  assign full_o  = full_q;
  assign ovf_o   = ovf_q;

  // Next-state: count accepted writes, flag writes past DEPTH, drain resets.
  always_comb begin
    cnt_d  = cnt_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    if (wr_req_i) begin
      if (room) cnt_d = cnt_q + CNT_W'(1);
      else      ovf_d = 1'b1;
    end
    if (clr_i) begin
      cnt_d  = '0;
      full_d = 1'b0;
    end
    if (set_full_i) full_d = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: rtl/su_add_scheduler.sv
// Ping-pong psum bank scheduler between the PE array and the psum adder.
// The adder writes into the active bank; a finished bank is marked full and
// drained by the consumer while the next tile fills the other bank.
module su_add_scheduler import su_pkg::*; #(
  parameter  int DEPTH  = SU_DEPTH,
  parameter  int TILE_W = SU_TILE_W,
  localparam int ADDR_W = su_addr_w(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  input  logic [SU_CFG_W-1:0] cfg_irrel_num,
  input  logic [SU_CFG_W-1:0] cfg_rel_num,
  input  logic [TILE_W-1:0]   cfg_tiles,
  input  logic                pe_done,
  input  logic                su_add_finish,
  input  logic                psum_gbf_w_en,
  input  logic [ADDR_W-1:0]   psum_gbf_w_addr,
  output logic                pe_psum_finish,
  output logic [SU_CFG_W-1:0] irrel_num,
  output logic [SU_CFG_W-1:0] rel_num,
  output logic                conv_finish,
  output logic [1:0]          bank_w_en,
  output logic [ADDR_W-1:0]   bank_w_addr,
  output logic                drain_req,
  output logic                drain_bank,
  input  logic                drain_ack,
  output logic                pe_stall,
  output logic                busy,
  output logic                err_ovf
);

  su_state_e           state_q, state_d;
  logic                active_q, active_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [TILE_W-1:0]   tiles_q;
  logic [SU_CFG_W-1:0] irrel_q, rel_q;
  logic                cfg_load;
  logic                in_add;
  logic [1:0]          full, wr_req, wr_ok, set_full, drain_clr, ovf;

  assign in_add = (state_q == S_ADD);

  // Drain the oldest full bank; with both full the active one is the newer.
  assign drain_req  = |full;
  assign drain_bank = (&full) ? ~active_q : full[1];

  for (genvar k = 0; k < 2; k++) begin : g_bank
    assign wr_req[k]    = in_add & psum_gbf_w_en & (active_q == 1'(k));
    assign set_full[k]  = in_add & su_add_finish & (active_q == 1'(k));
    assign drain_clr[k] = drain_ack & drain_req & (drain_bank == 1'(k));

    psum_bank_tracker #(.DEPTH(DEPTH)) u_trk (
      .clk        (clk),
      .reset      (reset),
      .wr_req_i   (wr_req[k]),
      .set_full_i (set_full[k]),
      .clr_i      (drain_clr[k]),
      .wr_ok_o    (wr_ok[k]),
      .full_o     (full[k]),
      .ovf_o      (ovf[k])
    );
  end

  assign bank_w_en      = wr_ok;
  assign bank_w_addr    = in_add ? psum_gbf_w_addr : '0;
  assign pe_psum_finish = in_add;
  assign conv_finish    = (state_q == S_DONE);
  assign busy           = (state_q != S_IDLE);
  assign err_ovf        = |ovf;
  assign irrel_num      = irrel_q;
  assign rel_num        = rel_q;

  // Next-state, tile counting, bank swap and stall decode.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    tile_d   = tile_q;
    cfg_load = 1'b0;
    pe_stall = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_irrel_num != '0 && cfg_tiles != '0) begin
          cfg_load = 1'b1;
          tile_d   = '0;
          state_d  = S_WAIT_PE;
        end
      end
      S_WAIT_PE: if (pe_done) state_d = S_ADD;
      S_ADD: begin
        pe_stall = 1'b1;
        if (su_add_finish) begin
          tile_d  = tile_q + TILE_W'(1);
          state_d = (tile_q + TILE_W'(1) == tiles_q) ? S_FLUSH : S_SWAP;
        end
      end
      S_SWAP: begin
        if (full[~active_q]) begin
          pe_stall = 1'b1;
        end else begin
          active_d = ~active_q;
          state_d  = S_WAIT_PE;
        end
      end
      S_FLUSH: begin
        pe_stall = 1'b1;
        if (full == 2'b00) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, active bank, tile count and latched configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      active_q <= 1'b0;
      tile_q   <= '0;
      tiles_q  <= '0;
      irrel_q  <= '0;
      rel_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      tile_q   <= tile_d;
      if (cfg_load) begin
        tiles_q <= cfg_tiles;
        irrel_q <= cfg_irrel_num;
        rel_q   <= cfg_rel_num;
      end
    end
  end

endmodule

// File: tb/tb_su_add_scheduler.sv
// Randomized self-checking bench for su_add_scheduler. The reference keeps
// bank contents as counts, the full banks as a FIFO (front = oldest), and
// walks each convolution tile by tile.
module tb_su_add_scheduler;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [4:0] cfg_irrel_num = '0, cfg_rel_num = '0;
  logic [7:0] cfg_tiles = '0;
  logic       pe_done = 1'b0, su_add_finish = 1'b0;
  logic       psum_gbf_w_en = 1'b0;
  logic [4:0] psum_gbf_w_addr = '0;
  logic       drain_ack = 1'b0;
  logic       pe_psum_finish, conv_finish, drain_req, drain_bank;
  logic       pe_stall, busy, err_ovf;
  logic [4:0] irrel_num, rel_num, bank_w_addr;
  logic [1:0] bank_w_en;

  su_add_scheduler #(.DEPTH(DEPTH), .TILE_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid),
    .cfg_irrel_num(cfg_irrel_num), .cfg_rel_num(cfg_rel_num), .cfg_tiles(cfg_tiles),
    .pe_done(pe_done), .su_add_finish(su_add_finish),
    .psum_gbf_w_en(psum_gbf_w_en), .psum_gbf_w_addr(psum_gbf_w_addr),
    .pe_psum_finish(pe_psum_finish), .irrel_num(irrel_num), .rel_num(rel_num),
    .conv_finish(conv_finish), .bank_w_en(bank_w_en), .bank_w_addr(bank_w_addr),
    .drain_req(drain_req), .drain_bank(drain_bank), .drain_ack(drain_ack),
    .pe_stall(pe_stall), .busy(busy), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_wen = 0;

  // reference model
  int m_q[$];
  int m_cnt[2];
  int m_act = 0;
  bit m_ovf = 1'b0;
  int m_irrel = 0, m_rel = 0;
  // expected phase-level outputs
  bit e_busy, e_stall, e_psf, e_cf, e_add, e_fin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rnd_ack(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic bit has(input int b);
    foreach (m_q[i]) if (m_q[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_exp(input bit b, input bit s, input bit p, input bit c, input bit a);
    e_busy = b; e_stall = s; e_psf = p; e_cf = c; e_add = a;
  endtask

  task automatic noise(input bit pe);
    psum_gbf_w_en   = 1'($urandom_range(0, 1));
    psum_gbf_w_addr = 5'($urandom);
    pe_done         = pe ? 1'($urandom_range(0, 1)) : 1'b0;
    cfg_valid       = 1'($urandom_range(0, 1));
    cfg_irrel_num   = 5'($urandom);
    cfg_rel_num     = 5'($urandom);
    cfg_tiles       = 8'($urandom);
  endtask

  // One clock: check every output against the model, then apply the edge.
  task automatic cyc(input bit ack);
    logic [1:0] ew;
    logic [4:0] ea;
    bit wr;
    drain_ack = ack;
    #1;
    wr = e_add && psum_gbf_w_en;
    ew = (wr && m_cnt[m_act] < DEPTH) ? 2'(1 << m_act) : 2'b00;
    ea = e_add ? psum_gbf_w_addr : 5'd0;
    chk("busy", busy, e_busy);
    chk("pe_stall", pe_stall, e_stall);
    chk("pe_psum_finish", pe_psum_finish, e_psf);
    chk("conv_finish", conv_finish, e_cf);
    chk("bank_w_en", bank_w_en, ew);
    chk("bank_w_addr", bank_w_addr, ea);
    chk("irrel_num", irrel_num, m_irrel);
    chk("rel_num", rel_num, m_rel);
    chk("err_ovf", err_ovf, m_ovf);
    chk("drain_req", drain_req, m_q.size() > 0);
    if (m_q.size() > 0) chk("drain_bank", drain_bank, m_q[0]);
    if (bank_w_en != 2'b00) n_wen++;
    @(posedge clk);
    if (ack && m_q.size() > 0) begin
      m_cnt[m_q[0]] = 0;
      void'(m_q.pop_front());
    end
    if (wr) begin
      if (m_cnt[m_act] < DEPTH) m_cnt[m_act]++;
      else m_ovf = 1'b1;
    end
    if (e_fin) m_q.push_back(m_act);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cfg_valid = 1'b0; pe_done = 1'b0; su_add_finish = 1'b0;
    psum_gbf_w_en = 1'b1; psum_gbf_w_addr = 5'($urandom);
    @(posedge clk); #1;
    m_q.delete(); m_cnt[0] = 0; m_cnt[1] = 0; m_act = 0; m_ovf = 1'b0;
    m_irrel = 0; m_rel = 0; e_fin = 1'b0;
    set_exp(0, 0, 0, 0, 0);
    cyc(1'b1);
    reset = 1'b0;
    psum_gbf_w_en = 1'b0;
  endtask

  // One full convolution. fixw >= 0 gives exactly fixw back-to-back writes
  // per tile; otherwise a random count in 0..maxw with random gaps.
  task automatic run_conv(input int irrel, input int rel, input int tiles,
                          input int fixw, input int maxw, input int ackpct);
    int nw, w, k;
    e_fin = 1'b0;
    set_exp(0, 0, 0, 0, 0);
    cfg_valid = 1'b1; cfg_irrel_num = 5'(irrel); cfg_rel_num = 5'(rel); cfg_tiles = 8'(tiles);
    pe_done = 1'b0; su_add_finish = 1'b0;
    psum_gbf_w_en = 1'($urandom_range(0, 1)); psum_gbf_w_addr = 5'($urandom);
    cyc(rnd_ack(ackpct));
    m_irrel = irrel; m_rel = rel;
    for (int t = 0; t < tiles; t++) begin
      set_exp(1, 0, 0, 0, 0);
      repeat ($urandom_range(0, 2)) begin noise(1'b0); cyc(rnd_ack(ackpct)); end
      noise(1'b0); pe_done = 1'b1; cyc(rnd_ack(ackpct));
      set_exp(1, 1, 1, 0, 1);
      nw = (fixw >= 0) ? fixw : int'($urandom_range(0, maxw));
      w = 0;
      while (w < nw) begin
        noise(1'b1);
        if (fixw >= 0) psum_gbf_w_en = 1'b1;
        cyc(rnd_ack(ackpct));
        if (psum_gbf_w_en) w++;
      end
      noise(1'b1);
      if (fixw >= 0) psum_gbf_w_en = 1'b0;
      su_add_finish = 1'b1; e_fin = 1'b1;
      cyc(rnd_ack(ackpct));
      su_add_finish = 1'b0; e_fin = 1'b0;
      if (t == tiles - 1) begin
        set_exp(1, 1, 0, 0, 0);
        k = 0;
        while (m_q.size() > 0 && k < 100) begin
          noise(1'b1); cyc(k >= 3 || rnd_ack(ackpct)); k++;
        end
        noise(1'b1); cyc(rnd_ack(ackpct));
        set_exp(1, 0, 0, 1, 0);
        noise(1'b1); cyc(rnd_ack(ackpct));
      end else begin
        k = 0;
        while (has(1 - m_act) && k < 100) begin
          set_exp(1, 1, 0, 0, 0);
          noise(1'b1); cyc(k >= 3 || rnd_ack(ackpct)); k++;
        end
        set_exp(1, 0, 0, 0, 0);
        noise(1'b1); cyc(rnd_ack(ackpct));
        m_act = 1 - m_act;
      end
    end
    set_exp(0, 0, 0, 0, 0);
    cfg_valid = 1'b0; pe_done = 1'b0; psum_gbf_w_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pcts[4] = '{0, 25, 60, 100};
    do_reset();
    set_exp(0, 0, 0, 0, 0);
    cyc(1'b0);

    // single tile, four writes, drained only in FLUSH
    run_conv(2, 6, 1, 4, 0, 0);
    cyc(1'b0);
    // three tiles with drain held off: SWAP blocks until bank0 drains
    run_conv(1, 2, 3, -1, 10, 0);

    for (int i = 0; i < 25; i++)
      run_conv(int'($urandom_range(1, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(1, 5)), -1,
               ($urandom_range(0, 3) == 0) ? 36 : 8, pcts[$urandom_range(0, 3)]);

    // reset in the middle of ADD drops everything
    cfg_valid = 1'b1; cfg_irrel_num = 5'd4; cfg_rel_num = 5'd3; cfg_tiles = 8'd2;
    set_exp(0, 0, 0, 0, 0); cyc(1'b0);
    cfg_valid = 1'b0; m_irrel = 4; m_rel = 3;
    set_exp(1, 0, 0, 0, 0); pe_done = 1'b1; cyc(1'b0); pe_done = 1'b0;
    set_exp(1, 1, 1, 0, 1);
    repeat (3) begin psum_gbf_w_en = 1'b1; psum_gbf_w_addr = 5'($urandom); cyc(1'b0); end
    do_reset();

    // zero tiles / zero irrel strobes must be ignored
    cfg_valid = 1'b1; cfg_irrel_num = 5'd5; cfg_rel_num = 5'd1; cfg_tiles = 8'd0;
    set_exp(0, 0, 0, 0, 0); cyc(1'b1);
    cfg_irrel_num = 5'd0; cfg_tiles = 8'd3; cyc(1'b0);
    cfg_valid = 1'b0; cyc(1'b0);

    // overflow: 33 writes in one ADD, only 32 reach the bank
    n_wen = 0;
    run_conv(3, 1, 1, 33, 0, 50);
    chk("ovf_wen_count", n_wen, 32);
    chk("ovf_sticky", err_ovf, 1);
    run_conv(7, 7, 2, -1, 8, 60);
    do_reset();
    chk("ovf_cleared", err_ovf, 0);

    for (int i = 0; i < 8; i++)
      run_conv(int'($urandom_range(1, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(1, 4)), -1, 12, pcts[$urandom_range(0, 3)]);
    cyc(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/su_add_scheduler.md
SU_ADD_SCHEDULER -- requirements
Module: su_add_scheduler

Interface
REQ-001 Parameter DEPTH, default 32, SHALL set psum GBF bank depth in words; ADDR_W = clog2(DEPTH).
REQ-002 Parameter TILE_W, default 8, SHALL set tile counter width.
REQ-003 One clock; reset is synchronous and active-high. Ports clk and reset SHALL be the only clock/reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 cfg_valid  in  1  config strobe, sampled in IDLE only.
REQ-007 cfg_irrel_num / cfg_rel_num  in  5 each  irrelevant/relevant dimension counts for adder.
REQ-008 cfg_tiles  in  TILE_W  number of PE tiles per convolution.
REQ-009 pe_done  in  1  one-cycle pulse: PE array psums valid.
REQ-010 su_add_finish  in  1  adder completion pulse.
REQ-011 psum_gbf_w_en  in  1, psum_gbf_w_addr  in  ADDR_W  adder write request.
REQ-012 pe_psum_finish  out  1  level to adder: start/hold summation.
REQ-013 irrel_num / rel_num  out  5 each  registered config to adder.
REQ-014 conv_finish  out  1  one-cycle pulse, to adder and top level.
REQ-015 bank_w_en  out  2, bank_w_addr  out  ADDR_W  per-bank write strobes and shared address.
REQ-016 drain_req  out  1, drain_bank  out  1, drain_ack  in  1  bank drain handshake.
REQ-017 pe_stall  out  1, busy  out  1, err_ovf  out  1 (sticky).

Function
REQ-018 FSM states SHALL be IDLE, WAIT_PE, ADD, SWAP, FLUSH, DONE.
REQ-019 IDLE: cfg_valid with cfg_irrel_num!=0 and cfg_tiles!=0 SHALL latch config, clear tile_cnt, go WAIT_PE; zero config SHALL be ignored.
REQ-020 WAIT_PE: pe_done SHALL go ADD; pe_psum_finish asserts the following cycle and holds until su_add_finish.
REQ-021 ADD: bank_w_en[k] = psum_gbf_w_en when k==active bank, else 0; bank_w_addr = psum_gbf_w_addr; zero latency, combinational.
REQ-022 ADD: per-bank write count SHALL saturate at DEPTH; writes beyond DEPTH SHALL be suppressed and set err_ovf.
REQ-023 su_add_finish in ADD SHALL deassert pe_psum_finish same edge, set full[active], increment tile_cnt, go SWAP, or FLUSH if tile_cnt+1==cfg_tiles.
REQ-024 SWAP: if full[~active]==0, toggle active and go WAIT_PE next cycle; else pe_stall=1 and wait.
REQ-025 Drain: drain_req=1 whenever any bank full; drain_bank = oldest full bank (not active when both full); drain_ack with drain_req clears full[drain_bank] that edge and resets its write count.
REQ-026 drain_ack without drain_req SHALL be ignored.
REQ-027 drain_ack and su_add_finish same cycle SHALL both take effect (different banks by construction).
REQ-028 FLUSH: wait until both full flags clear, then DONE.
REQ-029 DONE: conv_finish=1 for exactly one cycle, return to IDLE.
REQ-030 pe_done outside WAIT_PE SHALL be ignored; pe_stall=1 in ADD, SWAP-blocked, FLUSH.
REQ-031 busy=1 in every state except IDLE.

Reset
REQ-032 reset SHALL force IDLE, active=0, full=00, write counts/tile_cnt=0, irrel_num/rel_num=0, all outputs 0 incl. err_ovf; mid-operation reset drops all in-flight state with no conv_finish.

Structure
REQ-033 State encoding, DEPTH default and ADDR_W derivation SHALL live in shared package su_pkg.
REQ-034 Bank bookkeeping (full flag, write count, overflow) SHALL be one sub-module psum_bank_tracker, instantiated twice.

Verification
REQ-035 cfg irrel=2, rel=6, tiles=1; pe_done; adder writes 4, su_add_finish -> bank_w_en=01 four cycles, FLUSH, drain_req bank0, ack -> conv_finish one pulse.
REQ-036 tiles=3, drain_ack held 0 -> tile 1 bank0, tile 2 bank1, SWAP blocks with pe_stall=1; ack bank0 -> active=0, WAIT_PE next cycle.
REQ-037 33 writes in one ADD -> bank_w_en asserted 32 times, err_ovf=1 until reset.
REQ-038 drain_ack and su_add_finish same cycle -> full[drained]=0 and full[active]=1 same edge.
REQ-039 reset asserted in ADD -> next cycle all outputs 0, state IDLE; cfg_tiles=0 strobe -> stays IDLE, busy=0.
